ysyx_25060170_exec_ctrl: RTL
============================

# ysyx_25060170_exec_ctrl

Multi-cycle sequencer for the NPC core. It steps one instruction at a time through fetch, decode, execute, optional memory access and writeback. It drives the fetch and load/store request handshakes and gates the PC and GPR write enables, which the decoder otherwise produces combinationally. It also detects `ebreak` and memory-response timeouts, and keeps cycle and retired-instruction counters for the simulator.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: max cycles from entering a request state to response before error; ≥2.
- `CNT_W`, 64: width of `cycle_cnt`/`instret`.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ifu_req_valid`  out  1  fetch request to instruction memory.
- `ifu_req_ready`  in  1  instruction memory accepts request.
- `ifu_rsp_valid`  in  1  fetched instruction available this cycle.
- `inst_we`  out  1  load instruction register (pulse).
- `dec_is_load` / `dec_is_store` / `dec_regw` / `dec_jump` / `dec_ebreak`  in  1 each  decoded flags of the instruction register.
- `lsu_req_valid`  out  1  data-memory request.
- `lsu_req_ready`  in  1  data memory accepts request.
- `lsu_rsp_valid`  in  1  load data ready / store complete.
- `gpr_we`  out  1  GPR write strobe.
- `pc_we`  out  1  PC update strobe.
- `pc_sel_jump`  out  1  PC source is jump target (valid with `pc_we`).
- `halted`  out  1  `ebreak` retired.
- `err`  out  1  fatal error.
- `err_code`  out  2  0 none, 1 fetch timeout, 2 LSU timeout, 3 illegal decode.
- `cycle_cnt`  out  CNT_W  running cycles.
- `instret`  out  CNT_W  retired instructions.

## Operation
States:
- FETCH_REQ:
  - `ifu_req_valid`=1, held until `ifu_req_ready`.
  - On handshake → FETCH_WAIT.
- FETCH_WAIT: on `ifu_rsp_valid` → DECODE, with `inst_we` pulsed in that same cycle.
- DECODE: flags sampled.
  - `dec_is_load && dec_is_store` → ERR, code 3.
  - `dec_ebreak` → HALT.
  - Otherwise → EXEC.
- EXEC:
  - Load or store → MEM_REQ.
  - Otherwise → WB.
- MEM_REQ:
  - `lsu_req_valid`=1, held until `lsu_req_ready`.
  - On handshake → MEM_WAIT.
- MEM_WAIT: on `lsu_rsp_valid` → WB.
- WB:
  - `pc_we`=1.
  - `gpr_we`=`dec_regw`.
  - `pc_sel_jump`=`dec_jump`.
  - → FETCH_REQ.
- HALT: terminal; `halted`=1.
- ERR: terminal; `err`=1, `err_code` held.

Request and response rules:
- `*_req_valid` is never withdrawn before ready.
- A response is accepted only in the matching WAIT state. Responses in any other state are ignored.
- A response is never accepted in the same cycle as its request handshake.

Watchdog:
- Cleared on entry to FETCH_REQ or MEM_REQ.
- Increments each cycle in REQ/WAIT.
- Reaching `MEM_TIMEOUT` without a response → ERR, with code 1 (fetch) or 2 (LSU).
- A response arriving in the same cycle the count is reached wins: no error.

Counters:
- `cycle_cnt` increments every cycle except in HALT/ERR.
- `instret` increments in every WB cycle and on DECODE→HALT.
- Both wrap modulo 2^CNT_W.

## Timing
Reset:
- State FETCH_REQ.
- All strobes 0; `halted`/`err` 0; `err_code` 0; counters 0; watchdog 0.
- `ifu_req_valid` is 1 in the first cycle after `rst_n` rises.
- Reset asserted mid-instruction aborts immediately. No `pc_we` or `gpr_we` is issued for the aborted instruction.

All outputs are decoded from the registered state; there are no combinational paths from inputs to `*_req_valid`.

Minimum latency, with ready asserted and the response one cycle after accept:
- ALU/jump instruction: 5 cycles (REQ, WAIT, DECODE, EXEC, WB).
- Load/store: 7 cycles.
- `pc_we` is a single-cycle pulse per retired instruction. `gpr_we` is never high outside WB.

Flags must stay stable from DECODE through WB; the instruction register is loaded only by `inst_we`.

## Structure
- Shared package `ysyx_25060170_pkg`:
  - State enum.
  - `ERR_NONE`/`ERR_IFU_TO`/`ERR_LSU_TO`/`ERR_ILLEGAL` constants (2-bit).
  - Default `MEM_TIMEOUT`.
- Sub-module `ysyx_25060170_watchdog`:
  - Inputs: clear, enable, limit.
  - Output: expire flag.
  - Instantiated once and shared by the fetch and LSU wait phases.
- Counters and FSM live in the top.

## Test plan
- ALU (`dec_regw`=1): ready tied high, response 1 cycle after accept → `pc_we` and `gpr_we` both pulse in cycle 5; `instret`=1, `cycle_cnt`=5 after the first WB.
- Load with `lsu_req_ready` delayed 3 cycles → `lsu_req_valid` held 4 cycles; WB in cycle 10; `gpr_we`=1. Store → WB with `gpr_we`=0, `pc_we`=1.
- Jump (`dec_jump`=1) → `pc_sel_jump`=1 coincident with `pc_we`; 0 otherwise.
- `dec_ebreak` after 3 retired instructions → `halted`=1, `instret`=4; `cycle_cnt` frozen; no further `ifu_req_valid`.
- MEM_TIMEOUT=8, fetch response never arrives → `err`=1, `err_code`=1 eight cycles after entering FETCH_REQ. Repeat with the response in exactly the 8th cycle → no error. Load and store flags both set → `err_code`=3.
- `rst_n` pulsed low during MEM_WAIT → outputs return to reset values asynchronously; no `gpr_we`; fetch restarts.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the NPC execution sequencer.
package ysyx_25060170_pkg;

  typedef enum logic [3:0] {
    S_FETCH_REQ  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_MEM_REQ    = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_WB         = 4'd6,
    S_HALT       = 4'd7,
    S_ERR        = 4'd8
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_IFU_TO  = 2'd1;
  localparam logic [1:0] ERR_LSU_TO  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int WD_W            = 16;

  // True while a memory request or its response is outstanding.
  function automatic logic is_mem_phase(input state_e s);
    return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
           (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_25060170_watchdog.sv
// Response watchdog shared by the fetch and load/store phases.
// expire is asserted in the limit-th cycle since the last clear; the count
// saturates there so the flag stays up until the next clear.
module ysyx_25060170_watchdog
  import ysyx_25060170_pkg::*;
#(
  parameter int W = WD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  assign expire = enable && (cnt >= (limit - W'(1)));

  // Count cycles spent waiting; restart whenever the sequencer leaves the memory phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/ysyx_25060170_exec_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Request/strobe outputs are decoded from the state register; inst_we and the
// WB strobes qualify that state with the response or the stable decode flags.
module ysyx_25060170_exec_ctrl
  import ysyx_25060170_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  output logic             inst_we,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_regw,
  input  logic             dec_jump,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic             gpr_we,
  output logic             pc_we,
  output logic             pc_sel_jump,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_e state;
  logic   wd_enable;
  logic   wd_clear;
  logic   wd_expire;
  logic   illegal;
  logic   retire;

  assign illegal   = dec_is_load && dec_is_store;
  assign wd_enable = is_mem_phase(state);
  assign wd_clear  = !wd_enable;
  assign retire    = (state == S_WB) || ((state == S_DECODE) && dec_ebreak && !illegal);

  assign ifu_req_valid = (state == S_FETCH_REQ);
  assign lsu_req_valid = (state == S_MEM_REQ);
  assign inst_we       = (state == S_FETCH_WAIT) && ifu_rsp_valid;
  assign pc_we         = (state == S_WB);
  assign gpr_we        = (state == S_WB) && dec_regw;
  assign pc_sel_jump   = (state == S_WB) && dec_jump;
  assign halted        = (state == S_HALT);
  assign err           = (state == S_ERR);

  ysyx_25060170_watchdog #(
    .W(WD_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .limit  (WD_W'(MEM_TIMEOUT)),
    .expire (wd_expire)
  );

  // Sequencer state and latched error cause; a response in the expiry cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH_REQ;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        S_FETCH_REQ: begin
          if (wd_expire) begin
            state    <= S_ERR;
            err_code <= ERR_IFU_TO;
          end else if (ifu_req_ready) begin
            state <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            state <= S_DECODE;
          end else if (wd_expire) begin
            state    <= S_ERR;
            err_code <= ERR_IFU_TO;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state    <= S_ERR;
            err_code <= ERR_ILLEGAL;
          end else if (dec_ebreak) begin
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_is_load || dec_is_store) begin
            state <= S_MEM_REQ;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM_REQ: begin
          if (wd_expire) begin
            state    <= S_ERR;
            err_code <= ERR_LSU_TO;
          end else if (lsu_req_ready) begin
            state <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            state <= S_WB;
          end else if (wd_expire) begin
            state    <= S_ERR;
            err_code <= ERR_LSU_TO;
          end
        end
        S_WB:   state <= S_FETCH_REQ;
        S_HALT: state <= S_HALT;
        S_ERR:  state <= S_ERR;
        default: begin
          state    <= S_ERR;
          err_code <= ERR_ILLEGAL;
        end
      endcase
    end
  end

  // Cycle and retired-instruction counters; both freeze once the core stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if ((state != S_HALT) && (state != S_ERR)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule
